blvds_transmitter: RTL and testbench
====================================

Name: blvds_transmitter

Overview:
- Frame transmitter for the 18-bit BLVDS link.
- Builds a complete frame: frame header, PACK_NUM packets (each with a packet header, data words and a packet epilog), then a frame epilog carrying the CRC. Data words are pulled from a show-ahead FIFO.
- Sits between the acquisition FIFO and the BLVDS serializer, and is the sending end of the link terminated by the BLVDS receiver.

Parameters:
- GAP_LEN, 128: minimum number of idle words between frames; must be >= 101, the receiver's inter-frame latency.
- IDLE_WORD, 18'h3FE00: word driven whenever no frame is in progress.

Ports:
- iCLK  in  1  clock
- iRST  in  1  reset, asynchronous, active-high
- iSTART  in  1  frame request; sampled only in IDLE
- iFORMAT  in  3  frame format
- iCHANNELS  in  4  channel mask
- iPACK_SIZE  in  8  mode/scale code
- iPACK_NUM  in  8  packets per frame, 1..255
- iSAMPLE_NUM  in  16  sample field per packet
- iFIFO_DATA  in  16  show-ahead FIFO data
- iFIFO_EMPTY  in  1  FIFO empty
- oFIFO_RD  out  1  FIFO read acknowledge
- oDATA_BLVDS  out  18  link word
- oBUSY  out  1  high from iSTART accept until GAP ends
- oDONE  out  1  1-cycle pulse after the last frame-epilog word
- oUNDERRUN_ERROR  out  1  sticky until the next accepted iSTART

Behaviour:
- Reset values: oDATA_BLVDS=IDLE_WORD; all other outputs 0; frame counter 0; CRC 0; state IDLE.
- oDATA_BLVDS is registered and updates every cycle. Words are contiguous, with no gaps inside a frame.
- IDLE: drive IDLE_WORD.
  - On iSTART=1 with iPACK_NUM!=0: latch the configuration and go to FHEAD1.
  - iSTART with iPACK_NUM=0 is ignored.
- Word formats, bits[17:16]=2'b11 for all service words:
  - FHEAD1 = {11,000,FORMAT,FRAME_CNT[1:0],PACK_NUM}
  - FHEAD2 = {11,001,0,CHANNELS,PACK_SIZE}
  - PHEAD1 = {11,010,PACK_CNT[4:0],SAMPLE_NUM[15:8]}
  - PHEAD2 = {11,011,00000,SAMPLE_NUM[7:0]}
  - PEPI1 = {11,110,00000,PCRC[15:8]}
  - PEPI2 = {11,11100000,PCRC[7:0]}
  - FEPI1 = {11,10000000,FCRC[15:8]}
  - FEPI2 = {11,101,00000,FCRC[7:0]}
  - Data word = {00,iFIFO_DATA}.
- Sequence: FHEAD1, FHEAD2, then PACK_NUM times (PHEAD1, PHEAD2, DATA, PEPI1, PEPI2), then FEPI1, FEPI2, then GAP.
- DATA state:
  - Emits exactly SAMPLE_NUM+8 words per packet.
  - The data counter is 17 bits, so SAMPLE_NUM=16'hFFFF gives 65543 words with no wrap.
- PACK_CNT:
  - Starts at 0 and increments after each PEPI2.
  - The 5-bit field wraps modulo 32.
- Sequencing decision: PACK_NUM is compared against the 8-bit packets-sent count.
- Frame CRC:
  - The 16-bit running sum of bits[15:0] of FHEAD1, FHEAD2, every PHEAD, every data word, PEPI1 and PEPI2 (epilog words after PCRC insertion).
  - FCRC = ~sum. FEPI words are not summed.
- Packet CRC:
  - PCRC = ~(16-bit sum of bits[15:0] of that packet's PHEAD1, PHEAD2 and data words).
  - Cleared at each PHEAD1.
- FIFO: oFIFO_RD = (state==DATA) && !iFIFO_EMPTY. This is combinational; iFIFO_DATA is captured on the same edge.
- Underrun (iFIFO_EMPTY=1 in DATA):
  - The next word is IDLE_WORD.
  - oUNDERRUN_ERROR<=1; go to GAP.
  - The frame is not completed, and oDONE is not pulsed.
- GAP:
  - Drive IDLE_WORD for GAP_LEN cycles; the counter is 8 bits.
  - Then return to IDLE and clear oBUSY.
  - FRAME_CNT increments (mod 4) only on a completed frame.
- iSTART outside IDLE is ignored.
- iRST mid-frame: immediate return to reset values. The receiver detects a collision.
- Latency: FHEAD1 appears on oDATA_BLVDS the 2nd rising edge after iSTART is sampled high.
- Frame length = 4 + PACK_NUM*(SAMPLE_NUM+12) words.

Optional Feature:
- BLVDS_TX_TEST_PATTERN_EN.
- Defined:
  - Data words are {00,pattern}, where pattern is a 16-bit counter reset to 0 at each FHEAD1 and incremented per data word.
  - The FIFO is ignored: oFIFO_RD=0 and no underrun is possible.
- Undefined: data words come from the FIFO as described above.

Test Plan:
- Single frame:
  - Stimulus: FORMAT=2, CHANNELS=4'hF, PACK_SIZE=8'h10, PACK_NUM=2, SAMPLE_NUM=4, FIFO preloaded with 24 words 0x0001..0x0018, iSTART pulse.
  - Response: FHEAD1=18'h30802, FHEAD2=18'h32F10, PHEAD1=18'h34000, PHEAD2=18'h36004, 12 data words, PEPI words; second packet PHEAD1=18'h34100; total 36 words; oDONE pulse.
  - Check: FCRC in FEPI1/FEPI2 equals the bench-computed ~sum.
- Gap/frame counter:
  - Stimulus: two back-to-back iSTART requests.
  - Response: >=128 words of 18'h3FE00 between FEPI2 and the next FHEAD1; second FHEAD1 has FRAME_CNT=1 (18'h30902); after 4 frames FRAME_CNT wraps to 0.
- Underrun:
  - Stimulus: FIFO empties after 5 data words.
  - Response: next word 18'h3FE00; oUNDERRUN_ERROR=1; GAP state; no oDONE; FRAME_CNT unchanged; error clears on the next accepted iSTART.
- Boundaries:
  - PACK_NUM=0: iSTART is ignored and oBUSY stays 0.
  - PACK_NUM=33: PACK_CNT field wraps 31->0, and 33 packets are still sent.
- Reset mid-DATA:
  - Stimulus: iRST asserted during DATA.
  - Response: oDATA_BLVDS=18'h3FE00 asynchronously, all flags 0, FRAME_CNT=0.
- Test pattern (BLVDS_TX_TEST_PATTERN_EN defined):
  - Stimulus: PACK_NUM=1, SAMPLE_NUM=0.
  - Response: 8 data words 18'h00000..18'h00007; oFIFO_RD never asserted.

Source files
------------

// File: rtl/blvds_transmitter.sv
// BLVDS frame transmitter: headers, PACK_NUM packets of FIFO data with CRC epilogs, then an idle gap. BLVDS_TX_TEST_PATTERN_EN swaps FIFO data for a per-frame counter.
// Latency: FHEAD1 on the 2nd edge after iSTART; backpressure: none from the link, an empty FIFO inside a packet aborts the frame (underrun).
module blvds_transmitter #(
  parameter int          GAP_LEN   = 128,
  parameter logic [17:0] IDLE_WORD = 18'h3FE00
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic [2:0]  iFORMAT,
  input  logic [3:0]  iCHANNELS,
  input  logic [7:0]  iPACK_SIZE,
  input  logic [7:0]  iPACK_NUM,
  input  logic [15:0] iSAMPLE_NUM,
  input  logic [15:0] iFIFO_DATA,
  input  logic        iFIFO_EMPTY,
  output logic        oFIFO_RD,
  output logic [17:0] oDATA_BLVDS,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oUNDERRUN_ERROR
);

  typedef enum logic [3:0] {
    IDLE, FHEAD1, FHEAD2, PHEAD1, PHEAD2, DATA, PEPI1, PEPI2, FEPI1, FEPI2, GAP
  } state_t;

  localparam logic [7:0] GAP_LAST = 8'(GAP_LEN - 1);

  state_t      state, stateNxt;
  logic [2:0]  format;
  logic [3:0]  channels;
  logic [7:0]  packSize, packNum, packCnt, gapCnt;
  logic [15:0] sampleNum, pSum, fSum, pCrc, fCrc, dataWord;
  logic [16:0] dataCnt;
  logic [1:0]  frameCnt;
  logic [17:0] word;
  logic        accept, lastData, lastPack, gapEnd, dataOk;

  assign accept   = (state == IDLE) && iSTART && (iPACK_NUM != 8'd0);
  assign lastData = (dataCnt == ({1'b0, sampleNum} + 17'd7));
  assign lastPack = ((packCnt + 8'd1) == packNum);
  assign gapEnd   = (gapCnt == GAP_LAST);
  assign pCrc     = ~pSum;
  assign fCrc     = ~fSum;

`ifdef BLVDS_TX_TEST_PATTERN_EN
  logic [15:0] patCnt;
  logic        unusedFifo;
  assign unusedFifo = ^{iFIFO_DATA, iFIFO_EMPTY};
  assign dataWord   = patCnt;
  assign dataOk     = 1'b1;
  assign oFIFO_RD   = 1'b0;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)                 patCnt <= '0;
    else if (state == FHEAD1) patCnt <= '0;
    else if (state == DATA)   patCnt <= patCnt + 16'd1;
  end
`else
  assign dataWord = iFIFO_DATA;
  assign dataOk   = !iFIFO_EMPTY;
  assign oFIFO_RD = (state == DATA) && !iFIFO_EMPTY;
`endif

  // The state names the word that goes out on the next edge.
  always_comb begin
    stateNxt = state;
    word     = IDLE_WORD;
    case (state)
      IDLE:   if (accept) stateNxt = FHEAD1;
      FHEAD1: begin word = {2'b11, 3'b000, format, frameCnt, packNum};         stateNxt = FHEAD2; end
      FHEAD2: begin word = {2'b11, 3'b001, 1'b0, channels, packSize};          stateNxt = PHEAD1; end
      PHEAD1: begin word = {2'b11, 3'b010, packCnt[4:0], sampleNum[15:8]};     stateNxt = PHEAD2; end
      PHEAD2: begin word = {2'b11, 3'b011, 5'b00000, sampleNum[7:0]};          stateNxt = DATA;   end
      DATA: begin
        if (dataOk) begin
          word = {2'b00, dataWord};
          if (lastData) stateNxt = PEPI1;
        end else begin
          stateNxt = GAP;
        end
      end
      PEPI1:  begin word = {2'b11, 3'b110, 5'b00000, pCrc[15:8]}; stateNxt = PEPI2; end
      PEPI2:  begin word = {2'b11, 3'b111, 5'b00000, pCrc[7:0]};  stateNxt = lastPack ? FEPI1 : PHEAD1; end
      FEPI1:  begin word = {2'b11, 3'b100, 5'b00000, fCrc[15:8]}; stateNxt = FEPI2; end
      FEPI2:  begin word = {2'b11, 3'b101, 5'b00000, fCrc[7:0]};  stateNxt = GAP;   end
      GAP:    if (gapEnd) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state           <= IDLE;
      oDATA_BLVDS     <= IDLE_WORD;
      oBUSY           <= 1'b0;
      oDONE           <= 1'b0;
      oUNDERRUN_ERROR <= 1'b0;
      format          <= '0;
      channels        <= '0;
      packSize        <= '0;
      packNum         <= '0;
      sampleNum       <= '0;
      frameCnt        <= '0;
      packCnt         <= '0;
      dataCnt         <= '0;
      gapCnt          <= '0;
      pSum            <= '0;
      fSum            <= '0;
    end else begin
      state       <= stateNxt;
      oDATA_BLVDS <= word;
      // First gap cycle of a frame that ended through its epilog, not an underrun.
      oDONE       <= (state == GAP) && (gapCnt == 8'd0) && !oUNDERRUN_ERROR;
      gapCnt      <= (state == GAP) ? gapCnt + 8'd1 : 8'd0;
      if (accept) begin
        format          <= iFORMAT;
        channels        <= iCHANNELS;
        packSize        <= iPACK_SIZE;
        packNum         <= iPACK_NUM;
        sampleNum       <= iSAMPLE_NUM;
        oBUSY           <= 1'b1;
        oUNDERRUN_ERROR <= 1'b0;
      end
      if ((state == GAP) && gapEnd) oBUSY <= 1'b0;
      case (state)
        FHEAD1: begin
          fSum    <= word[15:0];
          packCnt <= '0;
        end
        FHEAD2, PEPI1: fSum <= fSum + word[15:0];
        PHEAD1: begin
          fSum    <= fSum + word[15:0];
          pSum    <= word[15:0];
          dataCnt <= '0;
        end
        PHEAD2: begin
          fSum <= fSum + word[15:0];
          pSum <= pSum + word[15:0];
        end
        DATA: begin
          if (dataOk) begin
            fSum    <= fSum + word[15:0];
            pSum    <= pSum + word[15:0];
            dataCnt <= dataCnt + 17'd1;
          end else begin
            oUNDERRUN_ERROR <= 1'b1;
          end
        end
        PEPI2: begin
          fSum    <= fSum + word[15:0];
          packCnt <= packCnt + 8'd1;
        end
        FEPI2:   frameCnt <= frameCnt + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_blvds_transmitter.sv
// Scoreboarded bench for blvds_transmitter: frames are listed from the word-format rules, a monitor pops and compares every link word.
module tb_blvds_transmitter;

  localparam logic [17:0] IDLE = 18'h3FE00;
  localparam int          GLEN = 128;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iSTART;
  logic [2:0]  iFORMAT;
  logic [3:0]  iCHANNELS;
  logic [7:0]  iPACK_SIZE;
  logic [7:0]  iPACK_NUM;
  logic [15:0] iSAMPLE_NUM;
  logic [15:0] iFIFO_DATA;
  logic        iFIFO_EMPTY;
  logic        oFIFO_RD;
  logic [17:0] oDATA_BLVDS;
  logic        oBUSY;
  logic        oDONE;
  logic        oUNDERRUN_ERROR;

  int          checks   = 0;
  int          failures = 0;
  int          doneCnt  = 0;
  int          idleRun  = 0;
  bit          gapArmed = 1'b0;
  logic [17:0] prevWord = IDLE;
  logic [17:0] expWord;
  logic [1:0]  mFrameCnt = 2'd0;
  logic [17:0] expQ[$];
  logic [15:0] fifoQ[$];
  logic [15:0] dataQ[$];

  blvds_transmitter #(.GAP_LEN(GLEN), .IDLE_WORD(IDLE)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iFORMAT(iFORMAT),
    .iCHANNELS(iCHANNELS), .iPACK_SIZE(iPACK_SIZE), .iPACK_NUM(iPACK_NUM),
    .iSAMPLE_NUM(iSAMPLE_NUM), .iFIFO_DATA(iFIFO_DATA), .iFIFO_EMPTY(iFIFO_EMPTY),
    .oFIFO_RD(oFIFO_RD), .oDATA_BLVDS(oDATA_BLVDS), .oBUSY(oBUSY), .oDONE(oDONE),
    .oUNDERRUN_ERROR(oUNDERRUN_ERROR)
  );

  always #5 iCLK = ~iCLK;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endfunction

  task automatic fifoRefresh();
    iFIFO_EMPTY = (fifoQ.size() == 0);
    iFIFO_DATA  = (fifoQ.size() != 0) ? fifoQ[0] : 16'h0;
  endtask

  // Show-ahead FIFO: a read acknowledged at an edge retires the head word.
  always begin
    logic rd;
    @(posedge iCLK);
    rd = oFIFO_RD;
    #1;
    if (rd && fifoQ.size() != 0) void'(fifoQ.pop_front());
    fifoRefresh();
  end

  always @(negedge iCLK) begin
    if (iRST) begin
      prevWord = IDLE;
      gapArmed = 1'b0;
      idleRun  = 0;
    end else begin
`ifdef BLVDS_TX_TEST_PATTERN_EN
      if (oFIFO_RD) check("fifo_rd_in_pattern", 32'(oFIFO_RD), 32'd0);
`endif
      if (oDATA_BLVDS != IDLE) begin
        if (oDATA_BLVDS[17:13] == 5'b11000 && gapArmed)
          check("gap_len_ge_128", 32'(idleRun >= GLEN), 32'd1);
        if (expQ.size() == 0) begin
          check("unexpected_word", 32'(oDATA_BLVDS), 32'(IDLE));
        end else begin
          expWord = expQ.pop_front();
          check("link_word", 32'(oDATA_BLVDS), 32'(expWord));
        end
        idleRun  = 0;
        gapArmed = 1'b1;
      end else begin
        if (prevWord != IDLE && expQ.size() != 0)
          check("idle_inside_frame", 32'(oDATA_BLVDS), 32'(expQ[0]));
        idleRun++;
      end
      if (oDONE || prevWord[17:13] == 5'b11101)
        check("done_after_fepi2", 32'(oDONE), 32'(prevWord[17:13] == 5'b11101));
      if (oDONE) doneCnt++;
      prevWord = oDATA_BLVDS;
    end
  end

  // Lists a frame word by word from the format rules; stops early when the data runs out.
  function automatic bit buildFrame(input logic [2:0] fmt, input logic [3:0] ch, input logic [7:0] ps,
                                    input logic [7:0] pn, input logic [15:0] sn, input logic [1:0] fc);
    logic [15:0] fsum, psum, crc;
    logic [17:0] w;
    int          k;
    k    = 0;
    w    = {2'b11, 3'd0, fmt, fc, pn};     expQ.push_back(w); fsum = w[15:0];
    w    = {2'b11, 3'd1, 1'b0, ch, ps};    expQ.push_back(w); fsum += w[15:0];
    for (int p = 0; p < int'(pn); p++) begin
      w = {2'b11, 3'd2, 5'(p), sn[15:8]};  expQ.push_back(w); psum = w[15:0];  fsum += w[15:0];
      w = {2'b11, 3'd3, 5'd0, sn[7:0]};    expQ.push_back(w); psum += w[15:0]; fsum += w[15:0];
      for (int i = 0; i < int'(sn) + 8; i++) begin
        if (k >= dataQ.size()) return 1'b0;
        w = {2'b00, dataQ[k]}; k++;
        expQ.push_back(w); psum += w[15:0]; fsum += w[15:0];
      end
      crc = ~psum;
      w = {2'b11, 3'd6, 5'd0, crc[15:8]};  expQ.push_back(w); fsum += w[15:0];
      w = {2'b11, 3'd7, 5'd0, crc[7:0]};   expQ.push_back(w); fsum += w[15:0];
    end
    crc = ~fsum;
    expQ.push_back({2'b11, 3'd4, 5'd0, crc[15:8]});
    expQ.push_back({2'b11, 3'd5, 5'd0, crc[7:0]});
    return 1'b1;
  endfunction

  task automatic runFrame(input logic [2:0] fmt, input logic [3:0] ch, input logic [7:0] ps,
                          input logic [7:0] pn, input logic [15:0] sn, input int nAvail,
                          input bit seqData, input bit midStart, input int resetAt);
    int total, d0;
    bit expDone;
    total = int'(pn) * (int'(sn) + 8);
`ifndef BLVDS_TX_TEST_PATTERN_EN
    if (nAvail >= 0 && nAvail < total) total = nAvail;
`endif
    dataQ.delete();
    for (int i = 0; i < total; i++) begin
`ifdef BLVDS_TX_TEST_PATTERN_EN
      dataQ.push_back(16'(i));
`else
      dataQ.push_back(seqData ? 16'(i + 1) : 16'($urandom));
`endif
    end
`ifndef BLVDS_TX_TEST_PATTERN_EN
    foreach (dataQ[i]) fifoQ.push_back(dataQ[i]);
    fifoRefresh();
`endif
    expDone = (pn != 8'd0) ? buildFrame(fmt, ch, ps, pn, sn, mFrameCnt) : 1'b0;
    d0 = doneCnt;
    @(negedge iCLK);
    iFORMAT = fmt; iCHANNELS = ch; iPACK_SIZE = ps; iPACK_NUM = pn; iSAMPLE_NUM = sn;
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART      = 1'b0;
    iFORMAT     = 3'($urandom);
    iCHANNELS   = 4'($urandom);
    iPACK_SIZE  = 8'($urandom);
    iPACK_NUM   = 8'($urandom_range(1, 255));
    iSAMPLE_NUM = 16'($urandom);
    if (pn == 8'd0) begin
      repeat (4) begin
        check("busy_ignored_pn0", 32'(oBUSY), 32'd0);
        @(negedge iCLK);
      end
      return;
    end
    check("busy_after_start", 32'(oBUSY), 32'd1);
    check("underrun_cleared_on_start", 32'(oUNDERRUN_ERROR), 32'd0);
    check("latency_idle_edge1", 32'(oDATA_BLVDS), 32'(IDLE));
    @(negedge iCLK);
    check("latency_fhead1_edge2", 32'(oDATA_BLVDS[17:13]), 32'(5'b11000));
    if (resetAt > 0) begin
      repeat (resetAt) @(negedge iCLK);
      check("in_data_before_reset", 32'(oDATA_BLVDS[17:16]), 32'd0);
      #2 iRST = 1'b1;
      expQ.delete();
      fifoQ.delete();
      #1;
      check("rst_data", 32'(oDATA_BLVDS), 32'(IDLE));
      check("rst_busy", 32'(oBUSY), 32'd0);
      check("rst_done", 32'(oDONE), 32'd0);
      check("rst_underrun", 32'(oUNDERRUN_ERROR), 32'd0);
      check("rst_fifo_rd", 32'(oFIFO_RD), 32'd0);
      mFrameCnt = 2'd0;
      @(negedge iCLK);
      #2 iRST = 1'b0;
      fifoRefresh();
      return;
    end
    if (midStart) begin
      repeat (8) @(negedge iCLK);
      iSTART = 1'b1;
      @(negedge iCLK);
      iSTART = 1'b0;
    end
    for (int c = 0; c < 6000 && oBUSY; c++) @(negedge iCLK);
    check("busy_timeout", 32'(oBUSY), 32'd0);
    check("frame_words_left", 32'(expQ.size()), 32'd0);
    check("done_count", 32'(doneCnt - d0), 32'(expDone));
    check("underrun_flag", 32'(oUNDERRUN_ERROR), 32'(!expDone));
    if (expDone) mFrameCnt = mFrameCnt + 2'd1;
  endtask

  task automatic randFrame(input bit midStart);
    runFrame(3'($urandom), 4'($urandom), 8'($urandom), 8'($urandom_range(1, 5)),
             16'($urandom_range(0, 30)), -1, 1'b0, midStart, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    iRST = 1'b1; iSTART = 1'b0; iFORMAT = '0; iCHANNELS = '0; iPACK_SIZE = '0;
    iPACK_NUM = '0; iSAMPLE_NUM = '0; iFIFO_EMPTY = 1'b1; iFIFO_DATA = '0;
    repeat (3) @(negedge iCLK);
    #2 iRST = 1'b0;
    @(negedge iCLK);
    check("reset_data", 32'(oDATA_BLVDS), 32'(IDLE));
    check("reset_busy", 32'(oBUSY), 32'd0);
    check("reset_done", 32'(oDONE), 32'd0);
    check("reset_underrun", 32'(oUNDERRUN_ERROR), 32'd0);
    check("reset_fifo_rd", 32'(oFIFO_RD), 32'd0);

    runFrame(3'd2, 4'hF, 8'h10, 8'd2, 16'd4, -1, 1'b1, 1'b0, 0);
    randFrame(1'b1);
    randFrame(1'b0);
    randFrame(1'b0);
    randFrame(1'b0);
    runFrame(3'd5, 4'h3, 8'h22, 8'd2, 16'd10, 5, 1'b0, 1'b0, 0);
    randFrame(1'b0);
    runFrame(3'd1, 4'h1, 8'h01, 8'd0, 16'd3, -1, 1'b0, 1'b0, 0);
    runFrame(3'd7, 4'hA, 8'h55, 8'd33, 16'd0, -1, 1'b0, 1'b0, 0);
`ifdef BLVDS_TX_TEST_PATTERN_EN
    runFrame(3'd0, 4'h1, 8'h00, 8'd1, 16'd0, -1, 1'b0, 1'b0, 0);
`endif
    repeat (3) randFrame(1'b0);
    runFrame(3'd3, 4'hC, 8'h40, 8'd2, 16'd100, -1, 1'b0, 1'b0, 10);
    randFrame(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
